// File: rtl/axi4_slave_read_engine.sv
// AXI4 slave read engine: AR request queue, FIXED/INCR/WRAP beat address
// generation, synchronous word-memory reads and a 2-entry R skid buffer.
// Optional build macro ADDR_RANGE_CHECK_EN: beats whose word address is
// >= MEM_DEPTH return SLVERR without reading memory.
`timescale 1ns/1ps
module axi4_slave_read_engine #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int ID_WIDTH    = 4,
   parameter int MEM_DEPTH   = 1024,
   parameter int OUTSTANDING = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         arvalid,
   output logic                         arready,
   input  logic [ADDR_WIDTH-1:0]        araddr,
   input  logic [ID_WIDTH-1:0]          arid,
   input  logic [7:0]                   arlen,
   input  logic [2:0]                   arsize,
   input  logic [1:0]                   arburst,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic [ID_WIDTH-1:0]          rid,
   output logic [1:0]                   rresp,
   output logic                         rlast,
   output logic                         mem_rd_en,
   output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0]        mem_rdata,
   output logic                         busy
);

   localparam int MW  = $clog2(MEM_DEPTH);
   localparam int BSH = $clog2(DATA_WIDTH/8);
   localparam int QW  = $clog2(OUTSTANDING);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;
   typedef enum logic [1:0] {BT_FIXED, BT_INCR, BT_WRAP} btype_t;

   // AR queue
   logic [ADDR_WIDTH-1:0] r_q_addr  [OUTSTANDING];
   logic [ID_WIDTH-1:0]   r_q_id    [OUTSTANDING];
   logic [7:0]            r_q_len   [OUTSTANDING];
   logic [2:0]            r_q_size  [OUTSTANDING];
   logic [1:0]            r_q_burst [OUTSTANDING];
   logic [QW-1:0]         r_q_wptr, r_q_rptr;
   logic [QW:0]           r_q_cnt, w_q_cnt_nxt;
   logic                  r_arready;
   logic                  w_push, w_pop;

   // head-of-queue decode
   logic [7:0] w_h_len;
   logic [2:0] w_h_size;
   logic [1:0] w_h_burst;
   logic       w_wrap_ok, w_h_err;
   btype_t     w_h_btype;

   // active burst
   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt, w_incr, w_seq, w_wmask;
   logic [8:0]            r_beats;
   logic [ID_WIDTH-1:0]   r_id;
   logic [2:0]            r_size;
   logic [7:0]            r_len;
   btype_t                r_btype;
   logic                  r_err;
   logic                  w_issue, w_in_range, w_credit;

   // read in flight (memory answers next cycle) and R skid buffer
   logic                  r_pend_v, r_pend_last;
   logic [ID_WIDTH-1:0]   r_pend_id;
   logic [1:0]            r_pend_resp;
   logic [DATA_WIDTH-1:0] w_pend_data;
   logic [DATA_WIDTH-1:0] r_b_data [2];
   logic [ID_WIDTH-1:0]   r_b_id   [2];
   logic [1:0]            r_b_resp [2];
   logic                  r_b_last [2];
   logic                  r_b_wptr, r_b_rptr;
   logic [1:0]            r_b_cnt;
   logic                  w_rpop, w_bpush, w_bpop;

   assign w_push  = arvalid && r_arready;
   assign arready = r_arready;

   // next queue occupancy
   always_comb begin
      w_q_cnt_nxt = r_q_cnt;
      if (w_push && !w_pop)
         w_q_cnt_nxt = r_q_cnt + (QW+1)'(1);
      else if (!w_push && w_pop)
         w_q_cnt_nxt = r_q_cnt - (QW+1)'(1);
   end

   // queue pointers, count and registered arready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q_wptr  <= '0;
         r_q_rptr  <= '0;
         r_q_cnt   <= '0;
         r_arready <= 1'b1;
      end else begin
         if (w_push) r_q_wptr <= r_q_wptr + QW'(1);
         if (w_pop)  r_q_rptr <= r_q_rptr + QW'(1);
         r_q_cnt   <= w_q_cnt_nxt;
         r_arready <= (w_q_cnt_nxt != (QW+1)'(OUTSTANDING));
      end
   end

   // queue storage
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_addr[r_q_wptr]  <= araddr;
         r_q_id[r_q_wptr]    <= arid;
         r_q_len[r_q_wptr]   <= arlen;
         r_q_size[r_q_wptr]  <= arsize;
         r_q_burst[r_q_wptr] <= arburst;
      end
   end

   assign w_h_len   = r_q_len[r_q_rptr];
   assign w_h_size  = r_q_size[r_q_rptr];
   assign w_h_burst = r_q_burst[r_q_rptr];
   assign w_wrap_ok = (w_h_len == 8'd1) || (w_h_len == 8'd3) ||
                      (w_h_len == 8'd7) || (w_h_len == 8'd15);
   assign w_h_err   = (w_h_burst == 2'b11) || ((w_h_burst == 2'b10) && !w_wrap_ok) ||
                      (w_h_size > 3'(BSH));

   // classify head burst; malformed WRAP and reserved types walk as INCR
   always_comb begin
      w_h_btype = BT_INCR;
      if (w_h_burst == 2'b00)
         w_h_btype = BT_FIXED;
      else if ((w_h_burst == 2'b10) && w_wrap_ok)
         w_h_btype = BT_WRAP;
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   assign w_credit = (r_b_cnt == 2'd0) || ((r_b_cnt == 2'd1) && !r_pend_v);

   // next state, queue pop and beat issue
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_q_cnt != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_credit) begin
               w_issue = 1'b1;
               if (r_beats == 9'd1) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // next beat address; WRAP keeps the upper bits of the wrap window
   always_comb begin
      w_incr  = ADDR_WIDTH'(1) << r_size;
      w_seq   = (r_addr & ~(w_incr - ADDR_WIDTH'(1))) + w_incr;
      w_wmask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
      case (r_btype)
         BT_FIXED: w_addr_nxt = r_addr;
         BT_WRAP:  w_addr_nxt = (r_addr & ~w_wmask) | (w_seq & w_wmask);
         default:  w_addr_nxt = w_seq;
      endcase
   end

   // active burst registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr  <= '0;
         r_beats <= '0;
         r_id    <= '0;
         r_size  <= '0;
         r_len   <= '0;
         r_btype <= BT_INCR;
         r_err   <= 1'b0;
      end else if (w_pop) begin
         r_addr  <= r_q_addr[r_q_rptr];
         r_beats <= {1'b0, w_h_len} + 9'd1;
         r_id    <= r_q_id[r_q_rptr];
         r_size  <= w_h_size;
         r_len   <= w_h_len;
         r_btype <= w_h_btype;
         r_err   <= w_h_err;
      end else if (w_issue) begin
         r_beats <= r_beats - 9'd1;
         r_addr  <= w_addr_nxt;
      end
   end

`ifdef ADDR_RANGE_CHECK_EN
   assign w_in_range = (r_addr >> BSH) < ADDR_WIDTH'(MEM_DEPTH);
`else
   assign w_in_range = 1'b1;
`endif

   assign mem_rd_en = w_issue && w_in_range;
   assign mem_addr  = MW'(r_addr >> BSH);

   // beat in flight: memory data arrives the cycle after issue
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend_v    <= 1'b0;
         r_pend_id   <= '0;
         r_pend_resp <= '0;
         r_pend_last <= 1'b0;
      end else begin
         r_pend_v    <= w_issue;
         r_pend_id   <= w_issue ? r_id : '0;
         r_pend_resp <= (w_issue && (r_err || !w_in_range)) ? 2'b10 : 2'b00;
         r_pend_last <= w_issue && (r_beats == 9'd1);
      end
   end

   assign w_pend_data = (r_pend_v && (r_pend_resp == 2'b00)) ? mem_rdata : '0;

   // returning beat bypasses the buffer when it is empty and the master is ready
   assign rvalid  = (r_b_cnt != 2'd0) || r_pend_v;
   assign w_rpop  = rvalid && rready;
   assign w_bpush = r_pend_v && !((r_b_cnt == 2'd0) && rready);
   assign w_bpop  = w_rpop && (r_b_cnt != 2'd0);

   // R buffer control
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_b_wptr <= 1'b0;
         r_b_rptr <= 1'b0;
         r_b_cnt  <= 2'd0;
      end else begin
         if (w_bpush) r_b_wptr <= ~r_b_wptr;
         if (w_bpop)  r_b_rptr <= ~r_b_rptr;
         case ({w_bpush, w_bpop})
            2'b10:   r_b_cnt <= r_b_cnt + 2'd1;
            2'b01:   r_b_cnt <= r_b_cnt - 2'd1;
            default: r_b_cnt <= r_b_cnt;
         endcase
      end
   end

   // R buffer storage
   always_ff @(posedge clk) begin
      if (w_bpush) begin
         r_b_data[r_b_wptr] <= w_pend_data;
         r_b_id[r_b_wptr]   <= r_pend_id;
         r_b_resp[r_b_wptr] <= r_pend_resp;
         r_b_last[r_b_wptr] <= r_pend_last;
      end
   end

   // R channel outputs: buffer head first, else the returning beat
   always_comb begin
      rdata = w_pend_data;
      rid   = r_pend_id;
      rresp = r_pend_resp;
      rlast = r_pend_last;
      if (r_b_cnt != 2'd0) begin
         rdata = r_b_data[r_b_rptr];
         rid   = r_b_id[r_b_rptr];
         rresp = r_b_resp[r_b_rptr];
         rlast = r_b_last[r_b_rptr];
      end
   end

   assign busy = (r_q_cnt != '0) || (r_state != S_IDLE) || r_pend_v || (r_b_cnt != 2'd0);

endmodule

// File: doc/axi4_slave_read_engine.md
Name: axi4_slave_read_engine

Overview:
Parametrised successor to the single-burst AXI4 slave read-data block. Accepts full AR-channel requests into an outstanding-request queue and generates per-beat addresses for FIXED, INCR and WRAP bursts. Reads a synchronous word memory and returns beats on the R channel with correct RID, RLAST and RRESP under arbitrary RREADY back-pressure. Sits between the AXI4 slave address decoder and the shared slave memory.

Parameters:
DATA_WIDTH, 32, R data width in bits (power of 2, 32..128)
ADDR_WIDTH, 16, AXI byte-address width
ID_WIDTH, 4, ARID/RID width
MEM_DEPTH, 1024, memory depth in DATA_WIDTH words
OUTSTANDING, 4, AR queue depth (power of 2, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
arvalid  in  1  AR valid
arready  out  1  AR ready (= queue not full)
araddr  in  ADDR_WIDTH  burst start byte address
arid  in  ID_WIDTH  request ID
arlen  in  8  beats minus 1
arsize  in  3  bytes per beat = 2**arsize; must be <= DATA_WIDTH/8
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
rvalid  out  1  R valid
rready  in  1  R ready
rdata  out  DATA_WIDTH  read data
rid  out  ID_WIDTH  echoed ARID
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat of burst
mem_rd_en  out  1  memory read strobe
mem_addr  out  clog2(MEM_DEPTH)  word address
mem_rdata  in  DATA_WIDTH  valid the cycle after mem_rd_en
busy  out  1  queue non-empty or burst active or R buffer non-empty

Behaviour:
- Reset (rst low, async): arready=1, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, mem_rd_en=0, busy=0; queue, state, counters cleared. Reset mid-burst discards all in-flight beats; no R beat follows deassertion until a new AR handshake.
- AR queue: FIFO of {addr,id,len,size,burst}, OUTSTANDING entries. Push on arvalid&&arready. arready=0 when full. Simultaneous push and pop when full: pop frees the slot next cycle only (arready is registered from count).
- FSM IDLE: queue non-empty -> pop head into burst registers (cur_addr, beats_left=len+1, id, size, type), go ISSUE.
- ISSUE: when beats_left>0 and R buffer credit>0, assert mem_rd_en with mem_addr=cur_addr>>log2(DATA_WIDTH/8) (truncated modulo MEM_DEPTH), decrement beats_left, advance cur_addr. After the last issue -> IDLE (next burst may issue the following cycle; back-to-back bursts have no bubble beyond one IDLE cycle).
- Address update: FIXED unchanged; INCR cur_addr += 2**size, aligned down to size after first beat; WRAP: wrap boundary = len+1 beats * 2**size, lower bits wrap within the aligned window. WRAP with len not in {1,3,7,15}, or arburst=11, -> whole burst SLVERR, addresses handled as INCR.
- Latency: AR handshake at cycle T -> pop T+1 -> first mem_rd_en T+2 -> rvalid T+3 with beat data.
- R buffer: 2-entry FIFO of {data,id,resp,last}; credit = 2 minus occupancy minus reads in flight. Guarantees no data loss under stall; full throughput (1 beat/cycle) with rready held high.
- R outputs held stable while rvalid&&!rready (AXI rule). rlast=1 only on beat len+1. rdata=0 on SLVERR beats.
- arsize > log2(DATA_WIDTH/8): burst accepted, all beats SLVERR.
- Bursts returned strictly in acceptance order, no interleaving.

Optional Feature:
ADDR_RANGE_CHECK_EN: when defined, any beat whose word address >= MEM_DEPTH returns rresp=10 and rdata=0 and does not assert mem_rd_en for that beat (slot still consumed, same latency). When undefined, addresses wrap modulo MEM_DEPTH and range alone never causes SLVERR.

Test Plan:
- INCR: araddr=0x0010, arlen=3, arsize=2, arid=5, rready=1 -> mem_addr 4,5,6,7; 4 beats, rid=5, rresp=00, rlast on beat 4 only, first rvalid 3 cycles after handshake.
- WRAP: araddr=0x0038, arlen=3, arsize=2 -> word addresses 14,15,12,13; rlast on 4th.
- FIXED: araddr=0x0020, arlen=7 -> mem_addr=8 for all 8 beats.
- Back-pressure: INCR len=7 with rready toggling 1,0,0,1 pattern -> 8 beats in order, outputs stable during stalls, no dropped or duplicated beats.
- Outstanding: issue 5 ARs (ids 1..5) with rready=0 -> arready drops after 4 accepted (+ pipeline); release rready -> rids 1..5 in order.
- Errors/reset: arburst=11 len=1 -> 2 beats rresp=10 rdata=0; with ADDR_RANGE_CHECK_EN araddr beyond MEM_DEPTH*4 -> SLVERR; assert rst mid-burst -> rvalid=0 immediately, arready=1, no residual beats.
